pool_2x2_ctrl: RTL and testbench

Sequencer for the 2x2 max-pool line unit (3 pooled outputs per 6-wide conv row pair). It accepts a raster stream of conv results, generates the pool unit's in_vld and 3-bit sel codes, and flags the beat on which the 3-wide pooled line is complete. It applies back-pressure when the downstream consumer is not ready, and counts rows and frames between the conv engine and the pooled-line consumer.

---
 rtl/pool_pkg.sv | 12 +
 rtl/pool_win_cnt.sv | 40 ++++
 rtl/pool_2x2_ctrl.sv | 84 ++++++++
 tb/tb_pool_2x2_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// pool_pkg: shared slot geometry, sel encodings and controller FSM states for the 2x2 max-pool line unit
package pool_pkg;
  localparam int POOL_SLOTS = 3;
  localparam int POOL_W = 6;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [2:0] SEL_INIT(input logic [1:0] slot);
    return {slot, 1'b0};
  endfunction
  function automatic logic [2:0] SEL_MAX(input logic [1:0] slot);
    return {slot, 1'b1};
  endfunction
endpackage

// File: rtl/pool_win_cnt.sv
// pool_win_cnt: raster col/row counters (clr/adv in; col, pooled row, first-write, final_beat, last_beat out)
module pool_win_cnt #(
  parameter int W = 6,
  parameter int H = 6,
  parameter int RCW = $clog2(H)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_clr,
  input  logic           i_adv,
  output logic [2:0]     o_col,
  output logic [RCW-2:0] o_prow,
  output logic           o_first,
  output logic           o_final_beat,
  output logic           o_last_beat
);
  logic [2:0]     r_col;
  logic [RCW-1:0] r_row;
  logic           w_col_end;
  logic           w_row_end;
  assign w_col_end = r_col == 3'(W - 1);
  assign w_row_end = r_row == RCW'(H - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_adv) begin
      r_col <= w_col_end ? 3'd0 : r_col + 3'd1;
      if (w_col_end) r_row <= w_row_end ? '0 : r_row + RCW'(1);
    end
  end
  assign o_col        = r_col;
  assign o_prow       = r_row[RCW-1:1];
  assign o_first      = !r_row[0] && !r_col[0];
  assign o_final_beat = r_row[0] && w_col_end;
  assign o_last_beat  = w_row_end && w_col_end;
endmodule

// File: rtl/pool_2x2_ctrl.sv
// pool_2x2_ctrl: 2x2 max-pool sequencer (start/abort/conv_vld in -> conv_rdy, pool_in_vld/sel, pool_out_vld, pool_row, busy, frame_done)
module pool_2x2_ctrl
  import pool_pkg::*;
#(
  parameter int CONV_W = 6,
  parameter int CONV_H = 6,
  parameter int ROW_CW = $clog2(CONV_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              conv_vld,
  output logic              conv_rdy,
  output logic              pool_in_vld,
  output logic [2:0]        pool_sel,
  output logic              pool_out_vld,
  input  logic              pool_out_rdy,
  output logic [ROW_CW-2:0] pool_row,
  output logic              busy,
  output logic              frame_done
);
  if (CONV_W != POOL_SLOTS * 2 || CONV_W != POOL_W) begin : g_bad_w
    $error("pool_2x2_ctrl: CONV_W must be 6");
  end
  if (CONV_H < 2 || CONV_H % 2 != 0) begin : g_bad_h
    $error("pool_2x2_ctrl: CONV_H must be even and >= 2");
  end
  state_t     r_state;
  logic       r_busy;
  logic       r_done;
  logic       w_run;
  logic       w_acc;
  logic       w_first;
  logic       w_final;
  logic       w_last;
  logic [2:0] w_col;
  pool_win_cnt #(.W(CONV_W), .H(CONV_H), .RCW(ROW_CW)) u_cnt (
    .clk(clk),
    .rst(rst),
    .i_clr(abort),
    .i_adv(w_acc),
    .o_col(w_col),
    .o_prow(pool_row),
    .o_first(w_first),
    .o_final_beat(w_final),
    .o_last_beat(w_last)
  );
  assign w_run        = r_state == RUN;
  assign conv_rdy     = w_run && !(w_final && !pool_out_rdy);
  assign w_acc        = conv_vld && conv_rdy;
  assign pool_in_vld  = w_acc;
  assign pool_sel     = w_first ? SEL_INIT(w_col[2:1]) : SEL_MAX(w_col[2:1]);
  assign pool_out_vld = w_run && conv_vld && w_final;
  assign busy         = r_busy;
  assign frame_done   = r_done;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (abort) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state <= RUN;
          r_busy  <= 1'b1;
        end
        RUN: if (w_acc && w_last) begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pool_2x2_ctrl.sv
// tb_pool_2x2_ctrl: directed bench with a raster-index model and a behavioural pool unit
module tb_pool_2x2_ctrl;
  localparam int H = 6;
  localparam int NB = 6 * H;
  logic clk = 0;
  logic rst;
  logic start = 0;
  logic abort = 0;
  logic conv_vld = 0;
  logic pool_out_rdy = 1;
  logic conv_rdy, pool_in_vld, pool_out_vld, busy, frame_done;
  logic [2:0] pool_sel;
  logic [1:0] pool_row;
  logic signed [7:0] conv_data = 0;
  logic signed [7:0] pu [3];
  int n_vec = 0;
  int n_err = 0;
  int m_ph = 0;
  int m_k = 0;
  int acc_n = 0;
  logic [23:0] lines [$];
  int sel_q [$];
  int ov_q [$];
  int ovrow_q [$];
  int d12 [12] = '{10, -3, 7, 7, -128, 5, 2, 20, -1, 8, 6, -7};
  int exp_sel [12] = '{0, 1, 2, 3, 4, 5, 1, 1, 3, 3, 5, 5};
  always #5 clk = ~clk;
  pool_2x2_ctrl #(.CONV_W(6), .CONV_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .conv_vld(conv_vld),
    .conv_rdy(conv_rdy), .pool_in_vld(pool_in_vld), .pool_sel(pool_sel),
    .pool_out_vld(pool_out_vld), .pool_out_rdy(pool_out_rdy), .pool_row(pool_row),
    .busy(busy), .frame_done(frame_done)
  );
  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int mx(input int a, input int b);
    return a > b ? a : b;
  endfunction
  function automatic bit m_fin();
    return ((m_k / 6) % 2 == 1) && (m_k % 6 == 5);
  endfunction
  always @(posedge clk)
    if (pool_in_vld) pu[pool_sel >> 1] <= pool_sel[0] ? 8'(mx(pu[pool_sel >> 1], conv_data)) : conv_data;
  always @(posedge clk or posedge rst) begin : model_upd
    bit acc;
    if (rst || abort) begin
      m_ph = 0;
      m_k = 0;
    end else begin
      acc = m_ph == 1 && conv_vld && !(m_fin() && !pool_out_rdy);
      if (m_ph == 0 && start) m_ph = 1;
      else if (m_ph == 1 && acc && m_k == NB - 1) m_ph = 2;
      else if (m_ph == 2) m_ph = 0;
      if (acc) m_k = (m_k + 1) % NB;
    end
  end
  always @(negedge clk) begin : compare
    int col, row;
    bit run, e_rdy;
    col = m_k % 6;
    row = m_k / 6;
    run = m_ph == 1;
    e_rdy = run && !(m_fin() && !pool_out_rdy);
    chk("conv_rdy", conv_rdy, e_rdy);
    chk("pool_in_vld", pool_in_vld, conv_vld && e_rdy);
    chk("pool_sel", pool_sel, (row % 2 == 0 && col % 2 == 0) ? col : (col | 1));
    chk("pool_out_vld", pool_out_vld, run && conv_vld && m_fin());
    chk("pool_row", pool_row, row / 2);
    chk("busy", busy, run);
    chk("frame_done", frame_done, m_ph == 2);
    if (conv_vld && conv_rdy) begin
      acc_n++;
      sel_q.push_back(pool_sel);
      if (pool_out_vld) begin
        ov_q.push_back(acc_n);
        ovrow_q.push_back(pool_row);
        lines.push_back({8'(mx(pu[2], conv_data)), pu[1], pu[0]});
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic send(input int d);
    int t;
    t = 0;
    conv_vld = 1;
    conv_data = 8'(d);
    @(negedge clk);
    while (!conv_rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!conv_rdy) chk("send_timeout", 0, 1);
    tick();
    conv_vld = 0;
  endtask
  initial begin
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_conv_rdy", conv_rdy, 0);
    chk("rst_sel", pool_sel, 0);
    chk("rst_done", frame_done, 0);
    tick();
    pulse_start();
    for (int i = 0; i < NB; i++) send(i < 12 ? d12[i] : i);
    chk("frame_done_pulse", frame_done, 1);
    chk("busy_fall", busy, 0);
    tick();
    chk("frame_done_clear", frame_done, 0);
    for (int i = 0; i < 12; i++) chk($sformatf("sel_seq%0d", i), sel_q[i], exp_sel[i]);
    chk("ov_count", ov_q.size(), 3);
    for (int i = 0; i < 3 && i < ov_q.size(); i++) begin
      chk($sformatf("ov_beat%0d", i), ov_q[i], 12 * (i + 1));
      chk($sformatf("ov_row%0d", i), ovrow_q[i], i);
    end
    chk("line_a", lines.size() > 0 ? int'(lines[0]) : -1, 24'h060814);
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      send(d12[i]);
      repeat (3) tick();
    end
    for (int i = 6; i < 11; i++) send(d12[i]);
    pool_out_rdy = 0;
    conv_vld = 1;
    conv_data = -8'sd7;
    repeat (4) begin
      @(negedge clk);
      chk("stall_rdy", conv_rdy, 0);
      chk("stall_in_vld", pool_in_vld, 0);
      chk("stall_ovld", pool_out_vld, 1);
      chk("stall_sel", pool_sel, 5);
    end
    tick();
    pool_out_rdy = 1;
    send(-7);
    chk("line_b_count", lines.size(), 4);
    chk("line_b", lines.size() > 3 ? int'(lines[3]) : -1, 24'h060814);
    for (int i = 12; i < NB; i++) send(i * 3 - 50);
    tick();
    pulse_start();
    for (int i = 0; i < 20; i++) send(i);
    chk("pre_abort_row", pool_row, 1);
    chk("pre_abort_sel", pool_sel, 3);
    abort = 1;
    tick();
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_rdy", conv_rdy, 0);
    chk("abort_sel", pool_sel, 0);
    chk("abort_row", pool_row, 0);
    pulse_start();
    chk("restart_busy", busy, 1);
    chk("restart_sel", pool_sel, 0);
    chk("restart_rdy", conv_rdy, 1);
    for (int i = 0; i < 5; i++) send(i);
    pulse_start();
    chk("start_in_run_sel", pool_sel, 5);
    chk("start_in_run_busy", busy, 1);
    send(0);
    chk("after_start_sel", pool_sel, 1);
    conv_vld = 1;
    @(posedge clk);
    #3 rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rdy", conv_rdy, 0);
    chk("arst_in_vld", pool_in_vld, 0);
    chk("arst_sel", pool_sel, 0);
    chk("arst_ovld", pool_out_vld, 0);
    conv_vld = 0;
    @(posedge clk);
    #3 rst = 0;
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
